ram_dp_sync_clr: RTL and testbench
==================================

Name: ram_dp_sync_clr

Overview:
- Parametrised true dual-port synchronous RAM, one clock domain. Successor to the fixed 8-bit, 2x8-entry dual-port store.
- Two fully independent ports: own enable, write enable, address, data in/out and read-valid strobe.
- After reset, a hardware clear engine zeroes every word. Both ports also share one address space and report same-address write collisions.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- busy  out  1  1 while reset or clear engine active; port requests ignored
- en_a  in  1  port A access request
- we_a  in  1  port A write (1) / read (0); valid with en_a
- addr_a  in  ADDR_W  port A word address
- din_a  in  WIDTH  port A write data
- dout_a  out  WIDTH  port A read data, registered
- dvalid_a  out  1  1-cycle pulse: dout_a updated
- en_b, we_b, addr_b, din_b, dout_b, dvalid_b: same as port A, for port B
- collision  out  1  1-cycle pulse: both ports wrote the same address

Behaviour:
- FSM states: CLEAR, READY.
- Reset (rst_n=0 at a rising edge):
  - state goes to CLEAR, clear counter goes to 0, busy=1.
  - dout_a=dout_b=0, dvalid_a=dvalid_b=0, collision=0.
- CLEAR:
  - Each cycle writes 0 to mem[counter], then the counter increments.
  - When counter==DEPTH-1 that word is written and the state goes to READY.
  - Clear therefore takes exactly DEPTH cycles after rst_n rises. busy falls on the edge that enters READY.
  - en_a/en_b are ignored: no writes, dvalid stays 0.
- Reset mid-clear: restarts at address 0. Reset in READY also re-clears the whole array.
- READY, read (en=1, we=0):
  - dout <= mem[addr] at the rising edge; dvalid=1 for the following cycle.
  - Latency is 1 cycle. Back-to-back reads are allowed every cycle.
- READY, write (en=1, we=1):
  - mem[addr] <= din at the rising edge.
  - dout is held, dvalid=0.
- en=0: dout is held and dvalid=0. No x-assignment of outputs ever.
- Same-port read-after-write to the same address in the next cycle returns the new data.
- Cross-port, same cycle, same address, one port reading and the other writing:
  - The reading port returns the OLD word (read-first), unless RAM_FWD_EN is defined.
  - collision is not asserted.
- Both ports write, same cycle, same address:
  - Port A data is stored; port B's write is dropped.
  - collision=1 on the next cycle only.
- Both ports read the same address: both return the same word, no conflict.
- Addresses are always in range, since DEPTH = 2**ADDR_W. No wrap or error handling is needed.
- Storage is an inferred register array. Read output is registered, one mem read per port.

Optional Feature:
- Macro RAM_FWD_EN.
- Defined: in the cross-port case (one port reads addr X while the other writes X in the same cycle), the reading port's dout takes the writer's din (write-first forwarding). dvalid is unchanged.
  - If both ports write X while neither reads, the behaviour is the baseline one.
  - A read on a port never forwards its own port's data. A port cannot read and write in the same cycle.
- Undefined: read-first behaviour as in Behaviour. No forwarding mux is synthesised.

Test Plan:
- Clear timing: hold rst_n=0 for 2 cycles, release → busy=1 for exactly 16 cycles (DEPTH=16). Then read all 16 addresses on A and B → each dout=0x00, dvalid pulses once per read.
- Basic access:
  - A writes 0x5A@3, next cycle A reads @3 → dout_a=0x5A one cycle later, dvalid_a=1 for one cycle.
  - B reads @3 → dout_b=0x5A.
- Write collision: A writes 0x11@7 and B writes 0x22@7 in the same cycle → collision=1 the next cycle only. A later read @7 → 0x11.
- Cross-port read-during-write: mem[5]=0x33. A writes 0x44@5 while B reads @5 → dout_b=0x33 without RAM_FWD_EN, 0x44 with it. A later read @5 → 0x44 in both builds.
- Reset mid-clear: rst_n low at clear cycle 8, high again → busy lasts a full 16 further cycles.
  - Requests with en_a=1, we_a=1 during busy → no memory change (reads return 0), dvalid stays 0.
- Independent parallel ops, WIDTH=16, ADDR_W=5: A writes 0xBEEF@31 while B reads @0 in the same cycle → dout_b=0x0000. Next cycle B reads @31 → 0xBEEF.

Source files
------------

// File: rtl/ram_dp_sync_clr.sv
// ram_dp_sync_clr: parametrised true dual-port synchronous RAM with a
// post-reset clear engine and same-address write collision reporting.
//
// Optional build macro: RAM_FWD_EN
//   defined   -> a port reading address X while the other port writes X in
//                the same cycle returns the writer's din (write-first).
//   undefined -> the reading port returns the old word (read-first) and no
//                forwarding mux exists.
//
// Port A wins a same-cycle, same-address write; port B's write is dropped
// and collision pulses for one cycle.

module ram_dp_sync_clr #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,

  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  din_a,
  output logic [WIDTH-1:0]  dout_a,
  output logic              dvalid_a,

  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  din_b,
  output logic [WIDTH-1:0]  dout_b,
  output logic              dvalid_b,

  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready;
  logic                clr_we;
  logic                wr_collide;
  logic                wr_b_keep;
  logic                collision_q;

  // Storage: no reset, the clear engine zeroes it word by word.
  logic [WIDTH-1:0]    mem [DEPTH];

  // Per-port views so both read paths come from one generate loop.
  logic                en_p     [2];
  logic                we_p     [2];
  logic [ADDR_W-1:0]   addr_p   [2];
  logic [WIDTH-1:0]    din_p    [2];
  logic [WIDTH-1:0]    dout_p   [2];
  logic                dvalid_p [2];
  logic                rd_p     [2];
  logic                wr_p     [2];

  assign en_p[0]   = en_a;
  assign en_p[1]   = en_b;
  assign we_p[0]   = we_a;
  assign we_p[1]   = we_b;
  assign addr_p[0] = addr_a;
  assign addr_p[1] = addr_b;
  assign din_p[0]  = din_a;
  assign din_p[1]  = din_b;

  assign ready = (state_q == ST_READY);
  assign busy  = ~ready | ~rst_n;

  // Clear engine writes only while running and not held in reset.
  assign clr_we = ~ready & rst_n;

  // State register and clear counter; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state: sweep every address once, leave CLEAR after the last word.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_READY;
      end
    end
  end

  // Both ports writing one word: A keeps it, B is dropped.
  assign wr_collide = wr_p[0] & wr_p[1] & (addr_a == addr_b);
  assign wr_b_keep  = wr_p[1] & ~wr_collide;

  // Memory write: clear engine has sole ownership while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr_b_keep) begin
        mem[addr_b] <= din_b;
      end
      if (wr_p[0]) begin
        mem[addr_a] <= din_a;
      end
    end
  end

  // Collision flag is a single-cycle pulse after the offending writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= wr_collide;
    end
  end

  assign collision = collision_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] rd_word;
      logic [WIDTH-1:0] dout_q;
      logic             dvalid_q;

      assign rd_p[gi] = ready & rst_n & en_p[gi] & ~we_p[gi];
      assign wr_p[gi] = ready & rst_n & en_p[gi] &  we_p[gi];

`ifdef RAM_FWD_EN
      localparam int OTHER = 1 - gi;
      logic fwd_hit;
      assign fwd_hit = wr_p[OTHER] & (addr_p[OTHER] == addr_p[gi]);
      assign rd_word = fwd_hit ? din_p[OTHER] : mem[addr_p[gi]];
`else
      assign rd_word = mem[addr_p[gi]];
`endif

      // Registered read port: dout holds unless a read is accepted.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dvalid_q <= rd_p[gi];
          if (rd_p[gi]) begin
            dout_q <= rd_word;
          end
        end
      end

      assign dout_p[gi]   = dout_q;
      assign dvalid_p[gi] = dvalid_q;
    end
  endgenerate

  assign dout_a   = dout_p[0];
  assign dvalid_a = dvalid_p[0];
  assign dout_b   = dout_p[1];
  assign dvalid_b = dvalid_p[1];

endmodule

// File: tb/tb_ram_dp_sync_clr.sv
// Directed bench for ram_dp_sync_clr: clear timing, basic access, write
// collision, cross-port read-during-write, reset mid-clear, and a wider
// instance (WIDTH=16, ADDR_W=5) for parallel independent accesses.

module tb_ram_dp_sync_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: default parameters
  logic       rst_n;
  logic       busy;
  logic       en_a, we_a, en_b, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b, dout_a, dout_b;
  logic       dvalid_a, dvalid_b, collision;

  // Instance 1: WIDTH=16, ADDR_W=5
  logic        rst1_n;
  logic        busy1;
  logic        en_a1, we_a1, en_b1, we_b1;
  logic [4:0]  addr_a1, addr_b1;
  logic [15:0] din_a1, din_b1, dout_a1, dout_b1;
  logic        dvalid_a1, dvalid_b1, collision1;

  ram_dp_sync_clr #(.WIDTH(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a), .dvalid_a(dvalid_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b), .dvalid_b(dvalid_b),
    .collision(collision)
  );

  ram_dp_sync_clr #(.WIDTH(16), .ADDR_W(5)) dut1 (
    .clk(clk), .rst_n(rst1_n), .busy(busy1),
    .en_a(en_a1), .we_a(we_a1), .addr_a(addr_a1), .din_a(din_a1),
    .dout_a(dout_a1), .dvalid_a(dvalid_a1),
    .en_b(en_b1), .we_b(we_b1), .addr_b(addr_b1), .din_b(din_b1),
    .dout_b(dout_b1), .dvalid_b(dvalid_b1),
    .collision(collision1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
  endtask

  task automatic port_a(input logic en, input logic we, input logic [3:0] ad, input logic [7:0] d);
    en_a = en; we_a = we; addr_a = ad; din_a = d;
  endtask

  task automatic port_b(input logic en, input logic we, input logic [3:0] ad, input logic [7:0] d);
    en_b = en; we_b = we; addr_b = ad; din_b = d;
  endtask

  // Count edges until busy drops, bounded so a stuck engine cannot hang.
  task automatic count_busy(output int n, output logic any_dv);
    n = 0;
    any_dv = 1'b0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (dvalid_a || dvalid_b) any_dv = 1'b1;
    end
  endtask

  int   n;
  int   n1;
  logic dv;
  logic [7:0] exp_x;

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    idle();
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    en_a1 = 0; we_a1 = 0; en_b1 = 0; we_b1 = 0;
    addr_a1 = '0; addr_b1 = '0; din_a1 = '0; din_b1 = '0;

    // Reset held for two edges
    tick();
    tick();
    check("rst_busy", busy, 1);
    check("rst_dout_a", dout_a, 0);
    check("rst_dout_b", dout_b, 0);
    check("rst_dvalid_a", dvalid_a, 0);
    check("rst_dvalid_b", dvalid_b, 0);
    check("rst_collision", collision, 0);

    // Clear timing
    rst_n = 1'b1; rst1_n = 1'b1;
    count_busy(n, dv);
    check("clear_cycles", n, 16);

    // Read every address on both ports back to back
    for (int i = 0; i < 16; i++) begin
      port_a(1, 0, 4'(i), 8'h00);
      port_b(1, 0, 4'(15 - i), 8'h00);
      tick();
      check($sformatf("clr_rd_a[%0d]", i), dout_a, 0);
      check($sformatf("clr_dv_a[%0d]", i), dvalid_a, 1);
      check($sformatf("clr_rd_b[%0d]", 15 - i), dout_b, 0);
      check($sformatf("clr_dv_b[%0d]", 15 - i), dvalid_b, 1);
    end
    idle();
    tick();
    check("idle_dv_a", dvalid_a, 0);
    check("idle_dv_b", dvalid_b, 0);

    // Basic write then read on A, then read on B
    port_a(1, 1, 4'd3, 8'h5A);
    tick();
    check("wr_dv_a", dvalid_a, 0);
    port_a(1, 0, 4'd3, 8'h00);
    tick();
    check("raw_dout_a", dout_a, 8'h5A);
    check("raw_dv_a", dvalid_a, 1);
    idle();
    port_b(1, 0, 4'd3, 8'h00);
    tick();
    check("hold_dout_a", dout_a, 8'h5A);
    check("pulse_dv_a", dvalid_a, 0);
    check("rd_b3", dout_b, 8'h5A);
    idle();

    // Write collision at address 7
    port_a(1, 1, 4'd7, 8'h11);
    port_b(1, 1, 4'd7, 8'h22);
    tick();
    check("coll_pulse", collision, 1);
    idle();
    tick();
    check("coll_clear", collision, 0);
    port_a(1, 0, 4'd7, 8'h00);
    port_b(1, 0, 4'd7, 8'h00);
    tick();
    check("coll_rd_a7", dout_a, 8'h11);
    check("coll_rd_b7", dout_b, 8'h11);
    idle();

    // Cross-port read during write at address 5
    port_a(1, 1, 4'd5, 8'h33);
    tick();
    port_a(1, 1, 4'd5, 8'h44);
    port_b(1, 0, 4'd5, 8'h00);
`ifdef RAM_FWD_EN
    exp_x = 8'h44;
`else
    exp_x = 8'h33;
`endif
    tick();
    check("xrw_dout_b", dout_b, exp_x);
    check("xrw_dv_b", dvalid_b, 1);
    check("xrw_no_coll", collision, 0);
    idle();
    port_b(1, 0, 4'd5, 8'h00);
    tick();
    check("xrw_after_b5", dout_b, 8'h44);
    idle();

    // Reset in READY, then reset again at clear cycle 8
    rst_n = 1'b0;
    tick();
    check("rr_busy", busy, 1);
    check("rr_dout_b", dout_b, 0);
    check("rr_dout_a", dout_a, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    port_a(1, 1, 4'd3, 8'hFF);
    port_b(1, 0, 4'd3, 8'h00);
    count_busy(n, dv);
    idle();
    check("mid_clear_cycles", n, 16);
    check("busy_no_dvalid", dv, 0);
    port_a(1, 0, 4'd3, 8'h00);
    port_b(1, 0, 4'd7, 8'h00);
    tick();
    check("mid_rd_a3", dout_a, 0);
    check("mid_rd_b7", dout_b, 0);
    idle();

    // Wide instance: parallel independent ops
    n1 = 0;
    while (busy1 && n1 < 200) begin
      tick();
      n1++;
    end
    check("w_ready", busy1, 0);
    en_a1 = 1; we_a1 = 1; addr_a1 = 5'd31; din_a1 = 16'hBEEF;
    en_b1 = 1; we_b1 = 0; addr_b1 = 5'd0;
    tick();
    check("w_rd_b0", dout_b1, 16'h0000);
    check("w_dv_b0", dvalid_b1, 1);
    en_a1 = 0; we_a1 = 0;
    addr_b1 = 5'd31;
    tick();
    check("w_rd_b31", dout_b1, 16'hBEEF);
    check("w_coll", collision1, 0);
    en_b1 = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
